// File: rtl/dut_port_arbiter.sv
// Round-robin arbiter sharing the dut write/read method interface between
// NUM_REQ requesters through a one-entry in-order command holding register.
module dut_port_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 1
) (
   input  logic                        CLK,
   input  logic                        RST_N,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]           rsp_data,
   output logic                        busy,
   output logic [ADDR_W-1:0]           write_address,
   output logic [DATA_W-1:0]           write_data,
   output logic                        write_en,
   input  logic                        write_rdy,
   output logic [ADDR_W-1:0]           read_address,
   output logic                        read_en,
   input  logic [DATA_W-1:0]           read_data,
   input  logic                        read_rdy
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Holding register (stage p0): one command waiting for the dut
   logic                 hold_valid;
   logic                 hold_write;
   logic [ADDR_W-1:0]    hold_addr;
   logic [DATA_W-1:0]    hold_data;
   logic [ID_W-1:0]      hold_id;
   logic [ID_W-1:0]      rr_ptr;

   logic                 issue_fire;
   logic                 can_accept;
   logic                 found;
   logic                 accept;
   logic [ID_W-1:0]      winner;

   function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
      id_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
   endfunction

   // Issue stage: only fire the held command when the matching dut port is ready
   always_comb begin
      write_en      = hold_valid & hold_write & write_rdy;
      read_en       = hold_valid & ~hold_write & read_rdy;
      issue_fire    = write_en | read_en;
      write_address = hold_valid ? hold_addr : '0;
      write_data    = hold_valid ? hold_data : '0;
      read_address  = hold_valid ? hold_addr : '0;
      busy          = hold_valid;
   end

   // Accept stage: first valid requester after rr_ptr, wrapping around
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid[(int'(rr_ptr) + 1 + k) % NUM_REQ]) begin
            found  = 1'b1;
            winner = ID_W'((int'(rr_ptr) + 1 + k) % NUM_REQ);
         end
      end
      can_accept = ~hold_valid | issue_fire;
      accept     = can_accept & found & ~RST_N;
      req_ready  = accept ? id_onehot(winner) : '0;
   end

   // Control state: holding-register occupancy, round-robin pointer, response pulse (stage p1)
   always_ff @(posedge CLK or posedge RST_N) begin
      if (RST_N) begin
         hold_valid <= 1'b0;
         rr_ptr     <= ID_W'(NUM_REQ - 1);
         rsp_valid  <= '0;
         rsp_data   <= '0;
      end else begin
         if (accept) begin
            hold_valid <= 1'b1;
            rr_ptr     <= winner;
         end else if (issue_fire) begin
            hold_valid <= 1'b0;
         end
         rsp_valid <= issue_fire ? id_onehot(hold_id) : '0;
         rsp_data  <= read_en ? read_data : '0;
      end
   end

   // Command fields are only meaningful while hold_valid, so they carry no reset
   always_ff @(posedge CLK) begin
      if (accept) begin
         hold_write <= req_write[winner];
         hold_addr  <= req_addr[winner*ADDR_W +: ADDR_W];
         hold_data  <= req_data[winner*DATA_W +: DATA_W];
         hold_id    <= winner;
      end
   end

endmodule

// File: tb/tb_dut_port_arbiter.sv
// Directed bench for dut_port_arbiter with two requesters.
module tb_dut_port_arbiter;

   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 3;
   localparam int DATA_W  = 1;

   logic                      CLK = 1'b0;
   logic                      RST_N;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic                      busy;
   logic [ADDR_W-1:0]         write_address;
   logic [DATA_W-1:0]         write_data;
   logic                      write_en;
   logic                      write_rdy;
   logic [ADDR_W-1:0]         read_address;
   logic                      read_en;
   logic [DATA_W-1:0]         read_data;
   logic                      read_rdy;

   int n_cmp = 0;
   int n_err = 0;

   dut_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
      .CLK(CLK), .RST_N(RST_N),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .write_address(write_address), .write_data(write_data), .write_en(write_en),
      .write_rdy(write_rdy), .read_address(read_address), .read_en(read_en),
      .read_data(read_data), .read_rdy(read_rdy)
   );

   // Free-running clock
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST_N     = 1'b1;
      req_valid = '0;
      req_write = '0;
      req_addr  = '0;
      req_data  = '0;
      write_rdy = 1'b0;
      read_rdy  = 1'b0;
      read_data = '0;
      repeat (2) tick();

      // Reset values, including req_ready held low while requests are present
      req_valid = 2'b11;
      req_write = 2'b11;
      req_addr  = {3'd2, 3'd1};
      req_data  = 2'b01;
      write_rdy = 1'b1;
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_write_en", write_en, 0);
      chk("rst_read_en", read_en, 0);
      chk("rst_write_addr", write_address, 0);
      chk("rst_write_data", write_data, 0);
      chk("rst_read_addr", read_address, 0);

      // Two continuous writers alternate, requester 0 first
      RST_N = 1'b0;
      #1;
      chk("rr_first_ready", req_ready, 2'b01);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("rr_write_en", write_en, 1);
         chk("rr_write_addr", write_address, (k % 2) ? 2 : 1);
         chk("rr_write_data", write_data, (k % 2) ? 0 : 1);
         chk("rr_req_ready", req_ready, 1 << (1 - (k % 2)));
         chk("rr_rsp_valid", rsp_valid, (k == 0) ? 0 : (1 << ((k - 1) % 2)));
         tick();
      end
      req_valid = '0;
      tick();
      chk("drain_rsp0", rsp_valid, 2'b01);
      tick();
      chk("drain_busy", busy, 0);
      chk("drain_rsp", rsp_valid, 0);

      // Write from requester 0, then read of the same address from requester 1
      read_rdy  = 1'b1;
      read_data = 1'b1;
      req_valid = 2'b01;
      req_write = 2'b01;
      req_addr  = {3'd0, 3'd3};
      req_data  = 2'b01;
      #1;
      chk("wr_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b10;
      req_write = 2'b01;
      req_addr  = {3'd3, 3'd3};
      #1;
      chk("wr_write_en", write_en, 1);
      chk("wr_write_addr", write_address, 3);
      chk("wr_write_data", write_data, 1);
      chk("wr_read_en", read_en, 0);
      chk("rd_ready", req_ready, 2'b10);
      tick();
      req_valid = '0;
      #1;
      chk("rd_read_en", read_en, 1);
      chk("rd_read_addr", read_address, 3);
      chk("wr_rsp_valid", rsp_valid, 2'b01);
      chk("wr_rsp_data", rsp_data, 0);
      tick();
      chk("rd_rsp_valid", rsp_valid, 2'b10);
      chk("rd_rsp_data", rsp_data, 1);
      chk("rd_busy", busy, 0);

      // Write stalled on write_rdy while a read waits on the other port
      write_rdy = 1'b0;
      req_valid = 2'b01;
      req_write = 2'b01;
      req_addr  = {3'd6, 3'd5};
      req_data  = 2'b01;
      #1;
      chk("st_ready0", req_ready, 2'b01);
      tick();
      req_valid = 2'b10;
      read_data = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("st_write_en", write_en, 0);
         chk("st_read_en", read_en, 0);
         chk("st_busy", busy, 1);
         chk("st_req_ready", req_ready, 0);
         chk("st_write_addr", write_address, 5);
         tick();
      end
      write_rdy = 1'b1;
      #1;
      chk("st_release_wen", write_en, 1);
      chk("st_release_ready", req_ready, 2'b10);
      tick();
      req_valid = '0;
      #1;
      chk("st_read_en", read_en, 1);
      chk("st_read_addr", read_address, 6);
      chk("st_write_en_off", write_en, 0);
      chk("st_wr_rsp", rsp_valid, 2'b01);
      tick();
      chk("st_rd_rsp", rsp_valid, 2'b10);
      chk("st_idle", busy, 0);

      // Reset while a read is stalled; requester 0 must regain first priority
      read_rdy  = 1'b0;
      req_valid = 2'b01;
      req_write = 2'b10;
      req_addr  = {3'd7, 3'd4};
      #1;
      chk("mr_ready0", req_ready, 2'b01);
      tick();
      req_valid = 2'b11;
      #1;
      chk("mr_read_en", read_en, 0);
      chk("mr_busy", busy, 1);
      chk("mr_read_addr", read_address, 4);
      RST_N = 1'b1;
      #1;
      chk("mr_busy_rst", busy, 0);
      chk("mr_addr_rst", read_address, 0);
      chk("mr_ready_rst", req_ready, 0);
      tick();
      chk("mr_rsp_rst", rsp_valid, 0);
      chk("mr_read_en_rst", read_en, 0);
      RST_N    = 1'b0;
      read_rdy = 1'b1;
      #1;
      chk("mr_first_ready", req_ready, 2'b01);
      chk("mr_dropped", read_en, 0);
      tick();
      req_valid = '0;
      #1;
      chk("mr_read_en2", read_en, 1);
      chk("mr_read_addr2", read_address, 4);
      tick();
      chk("mr_rsp", rsp_valid, 2'b01);
      tick();

      // Requester 1 alone issues four reads with toggling read data
      req_write = 2'b00;
      req_addr  = {3'd2, 3'd0};
      for (int k = 0; k < 6; k++) begin
         req_valid = (k < 4) ? 2'b10 : 2'b00;
         read_data = (k >= 1 && k <= 4) ? (((k - 1) % 2) == 0) : 1'b0;
         #1;
         chk("r4_req_ready", req_ready, (k < 4) ? 2'b10 : 2'b00);
         chk("r4_read_en", read_en, (k >= 1 && k <= 4) ? 1 : 0);
         chk("r4_rsp_valid", rsp_valid, (k >= 2) ? 2'b10 : 2'b00);
         chk("r4_rsp_data", rsp_data, (k >= 2) ? (((k - 2) % 2) == 0) : 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dut_port_arbiter.md
Name: dut_port_arbiter

Overview:
- Shares the single write/read method interface of the `dut` storage block between NUM_REQ requesters.
- Each requester issues single-beat write or read commands. The block round-robin arbitrates them into a one-entry command holding register, then issues the held command to the dut only when the dut's matching rdy is high.
- Read data is registered and returned to the originating requester one cycle after issue.
- Sits between the test/agent masters and `dut`; it is the only driver of the dut's write_*/read_* inputs.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 3, dut address width.
- DATA_W, 1, dut data width.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  reset; asynchronous and active-high (asserted = 1).
- req_valid  input  NUM_REQ  per-requester command valid.
- req_write  input  NUM_REQ  per-requester command type: 1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i in bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i in bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot accept; a command transfers when req_valid[i] & req_ready[i].
- rsp_valid  output  NUM_REQ  one-cycle completion pulse to the originating requester.
- rsp_data  output  DATA_W  read data qualified by rsp_valid; 0 for write completions.
- busy  output  1  holding register occupied.
- write_address  output  ADDR_W  to dut.
- write_data  output  DATA_W  to dut.
- write_en  output  1  to dut.
- write_rdy  input  1  from dut.
- read_address  output  ADDR_W  to dut.
- read_en  output  1  to dut.
- read_data  input  DATA_W  from dut; valid in the same cycle as read_en.
- read_rdy  input  1  from dut.

Behaviour:
- Reset values while RST_N = 1:
  - hold_valid = 0, rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - Outputs: rsp_valid = 0, rsp_data = 0, busy = 0, req_ready = 0, write_en = 0, read_en = 0.
  - Address/data outputs = 0.
- Holding register fields: hold_valid, hold_write, hold_addr, hold_data, hold_id.
- Issue stage (combinational from the holding register):
  - write_en = hold_valid & hold_write & write_rdy.
  - read_en = hold_valid & ~hold_write & read_rdy.
  - issue_fire = write_en | read_en.
  - write_address/write_data and read_address are driven from hold_addr/hold_data while hold_valid, else 0.
  - en is never asserted without the matching rdy.
- Accept stage:
  - can_accept = ~hold_valid | issue_fire, giving back-to-back throughput of one command per cycle.
  - When can_accept, search for the first requester with req_valid set, starting at index (rr_ptr+1) mod NUM_REQ and wrapping.
  - The winner gets req_ready = 1; all other bits stay 0. No winner means req_ready = 0.
  - req_ready must not depend on the winner's req_valid beyond selection; it is 0 for non-requesting indices.
- On accept (rising edge):
  - Load the holding register from the winner's fields and set hold_id = winner.
  - Set hold_valid = 1 and rr_ptr = winner.
  - rr_ptr is updated only on accept.
- On issue_fire without a new accept: hold_valid clears to 0.
- Response, registered, one cycle after issue_fire:
  - rsp_valid[hold_id] = 1 for exactly one cycle.
  - rsp_data = read_data sampled at issue for reads, 0 for writes.
  - rsp_valid is 0 in all other cycles.
- Stall behaviour:
  - If the needed rdy is low, the command stays held indefinitely with stable outputs and busy = 1.
  - New requests are not accepted during the stall.
  - A write stalled on write_rdy is not bypassed by a read, even if read_rdy = 1 (strict in-order).
- Simultaneous accept and issue in one cycle: the new command replaces the old one in the holding register. The response for the old command still occurs the next cycle.
- Requester i must hold req_valid and its fields stable until accepted. The block is not required to handle deassertion before accept.
- Reset asserted mid-operation:
  - The held command is dropped and not issued.
  - A pending rsp_valid is cleared.
  - After release, the first accept favours requester 0.
- busy = hold_valid.

Test Plan:
- Reset, then req_valid = 2'b11 continuously, both writes, write_rdy = 1 -> accepts alternate 0,1,0,1. write_en high every cycle from cycle 2. rsp_valid alternates 01,10 one cycle after each issue.
- Requester 0 writes addr 3 data 1; next cycle requester 1 reads addr 3 with read_data = 1 -> write_en with write_address = 3, write_data = 1. Then read_en with read_address = 3. rsp_valid = 2'b10 and rsp_data = 1 one cycle later.
- Hold write_rdy = 0 for 5 cycles with a write held and req_valid[1] = 1 -> write_en = 0, busy = 1, req_ready = 0 for 5 cycles. Issue on the cycle write_rdy rises; requester 1 accepted that same cycle.
- Write held with write_rdy = 0 and read_rdy = 1, read request pending on the other port -> read_en stays 0 until the write issues (no reordering).
- Assert RST_N while a read is held and read_rdy = 0 -> all outputs 0 next edge. After release, with req_valid = 2'b11, requester 0 is granted first.
- Only requester 1 valid for 4 reads, read_rdy = 1, read_data toggling 1,0,1,0 -> req_ready = 2'b10 each cycle. rsp_data = 1,0,1,0 on rsp_valid = 2'b10, each one cycle after its read_en.
